// File: rtl/ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : ifetch_unit
// Brief   : Instruction fetch front end. Holds the PC, issues credit-limited
//           in-order imem word requests, buffers responses in a FIFO for decode
//           and flushes/redirects on taken branches, dropping stale responses.
// Revision: 1.0 - initial release
// ============================================================================
module ifetch_unit #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          DEPTH      = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ready,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_inst_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc,
    input  logic        i_inst_ready
);

    localparam int                 c_ptr_w   = $clog2(DEPTH);
    localparam int                 c_cnt_w   = $clog2(DEPTH) + 1;
    localparam logic [c_cnt_w:0]   c_depth   = (c_cnt_w + 1)'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
    localparam logic [31:0]        c_nop     = 32'h0000_0013;

    logic [31:0]        r_pc;
    logic [c_cnt_w-1:0] r_count;
    logic [c_cnt_w-1:0] r_inflight;
    logic [c_cnt_w-1:0] r_drop;
    logic [c_ptr_w-1:0] r_fifo_rd;
    logic [c_ptr_w-1:0] r_fifo_wr;
    logic [c_ptr_w-1:0] r_tag_rd;
    logic [c_ptr_w-1:0] r_tag_wr;
    logic [31:0]        r_fifo_inst [DEPTH];
    logic [31:0]        r_fifo_pc   [DEPTH];
    logic [31:0]        r_tag_pc    [DEPTH];

    logic [c_cnt_w:0]   w_credit_used;
    logic               w_accept;
    logic               w_rsp;
    logic               w_rsp_drop;
    logic               w_push;
    logic               w_pop;
    logic [c_cnt_w-1:0] w_inflight_next;
    logic [c_cnt_w-1:0] w_count_next;
    logic               w_unused_redirect_lsb;

    // Every outstanding request owns a FIFO slot, so responses can never overflow it
    assign w_credit_used = {1'b0, r_inflight} + {1'b0, r_count};
    assign o_imem_req    = !i_rst && (w_credit_used < c_depth);
    assign o_imem_addr   = r_pc;

    assign w_accept   = o_imem_req && i_imem_ready;
    assign w_rsp      = i_imem_rvalid && (r_inflight != '0);
    assign w_rsp_drop = w_rsp && (r_drop != '0);
    assign w_push     = w_rsp && !w_rsp_drop && !i_redirect;
    assign w_pop      = o_inst_valid && i_inst_ready && !i_redirect;

    assign w_inflight_next = r_inflight + (w_accept ? c_cnt_one : '0)
                                        - (w_rsp    ? c_cnt_one : '0);

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + c_cnt_one;
            2'b01:   w_count_next = r_count - c_cnt_one;
            default: w_count_next = r_count;
        endcase
    end

    assign w_unused_redirect_lsb = ^i_redirect_pc[1:0];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc       <= RESET_ADDR;
            r_count    <= '0;
            r_inflight <= '0;
            r_drop     <= '0;
            r_fifo_rd  <= '0;
            r_fifo_wr  <= '0;
            r_tag_rd   <= '0;
            r_tag_wr   <= '0;
        end else begin
            r_inflight <= w_inflight_next;

            // The PC tag queue tracks every request, dropped or not, so it stays aligned
            if (w_accept) begin
                r_tag_pc[r_tag_wr] <= r_pc;
                r_tag_wr           <= r_tag_wr + c_ptr_one;
            end
            if (w_rsp) begin
                r_tag_rd <= r_tag_rd + c_ptr_one;
            end

            if (i_redirect) begin
                r_pc      <= {i_redirect_pc[31:2], 2'b00};
                r_count   <= '0;
                r_fifo_rd <= '0;
                r_fifo_wr <= '0;
                r_drop    <= w_inflight_next;
            end else begin
                if (w_accept) begin
                    r_pc <= r_pc + 32'd4;
                end
                if (w_rsp_drop) begin
                    r_drop <= r_drop - c_cnt_one;
                end
                if (w_push) begin
                    r_fifo_inst[r_fifo_wr] <= i_imem_rdata;
                    r_fifo_pc[r_fifo_wr]   <= r_tag_pc[r_tag_rd];
                    r_fifo_wr              <= r_fifo_wr + c_ptr_one;
                end
                if (w_pop) begin
                    r_fifo_rd <= r_fifo_rd + c_ptr_one;
                end
                r_count <= w_count_next;
            end
        end
    end

    assign o_inst_valid = (r_count != '0);
    assign o_inst       = o_inst_valid ? r_fifo_inst[r_fifo_rd] : c_nop;
    assign o_inst_pc    = o_inst_valid ? r_fifo_pc[r_fifo_rd]   : 32'h0000_0000;

endmodule
`default_nettype wire

// File: tb/tb_ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_ifetch_unit
// Brief   : Self-checking bench for ifetch_unit with a queue-based fetch model
//           and an in-order imem responder.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ifetch_unit;

    localparam int          DEPTH      = 2;
    localparam logic [31:0] RESET_ADDR = 32'h0000_0000;
    localparam logic [31:0] NOP        = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;

    always #5 clk = ~clk;

    ifetch_unit #(.RESET_ADDR(RESET_ADDR), .DEPTH(DEPTH)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .o_imem_req   (imem_req),
        .o_imem_addr  (imem_addr),
        .i_imem_ready (imem_ready),
        .i_imem_rvalid(imem_rvalid),
        .i_imem_rdata (imem_rdata),
        .i_redirect   (redirect),
        .i_redirect_pc(redirect_pc),
        .o_inst_valid (inst_valid),
        .o_inst       (inst),
        .o_inst_pc    (inst_pc),
        .i_inst_ready (inst_ready)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model: fetch state as plain integers and queues
    logic [31:0] m_pc   = RESET_ADDR;
    int          m_infl = 0;
    int          m_drop = 0;
    logic [63:0] m_fifo [$];
    logic [31:0] m_tags [$];

    // Instruction memory: outstanding accepted addresses with their accept cycle
    logic [31:0] mem_q [$];
    int          mem_t [$];

    logic [31:0] acc_q [$];
    logic [31:0] pop_q [$];

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h1F0F};
    endfunction

    task automatic cycle(input logic rst_i, input logic rdy, input logic resp,
                         input logic bogus, input logic redir,
                         input logic [31:0] rpc, input logic irdy);
        logic        rv_drive;
        logic        rv_real;
        logic [31:0] rdata_v;
        logic        m_req;
        logic        m_valid;
        logic [63:0] head;
        logic [31:0] exp_inst;
        logic [31:0] exp_ipc;
        logic        accept;
        logic        rv_model;
        logic        have_push;
        logic [63:0] push_v;
        logic [31:0] t;

        @(negedge clk);
        rv_real  = resp && !rst_i && (mem_q.size() != 0) && (mem_t[0] < cyc);
        rv_drive = rv_real || (bogus && !rst_i && (mem_q.size() == 0));
        rdata_v  = rv_real ? data_of(mem_q[0]) : (rv_drive ? $urandom : 32'h0);
        rst         = rst_i;
        imem_ready  = rdy;
        imem_rvalid = rv_drive;
        imem_rdata  = rdata_v;
        redirect    = redir;
        redirect_pc = rpc;
        inst_ready  = irdy;
        #1;

        m_req    = !rst_i && ((m_infl + m_fifo.size()) < DEPTH);
        m_valid  = (m_fifo.size() != 0);
        head     = m_valid ? m_fifo[0] : 64'h0;
        exp_inst = m_valid ? head[63:32] : NOP;
        exp_ipc  = m_valid ? head[31:0]  : 32'h0;

        if (imem_req !== m_req)
            $display("FAIL imem_req cyc=%0d got=%b exp=%b", cyc, imem_req, m_req);
        else n_pass++;
        n_checks++;
        if (!rst_i) begin
            if (imem_addr !== m_pc)
                $display("FAIL imem_addr cyc=%0d got=%h exp=%h", cyc, imem_addr, m_pc);
            else n_pass++;
            n_checks++;
            if (inst_valid !== m_valid)
                $display("FAIL inst_valid cyc=%0d got=%b exp=%b", cyc, inst_valid, m_valid);
            else n_pass++;
            n_checks++;
            if (inst !== exp_inst)
                $display("FAIL inst cyc=%0d got=%h exp=%h", cyc, inst, exp_inst);
            else n_pass++;
            n_checks++;
            if (inst_pc !== exp_ipc)
                $display("FAIL inst_pc cyc=%0d got=%h exp=%h", cyc, inst_pc, exp_ipc);
            else n_pass++;
            n_checks++;
        end

        if (rst_i) begin
            m_pc = RESET_ADDR;
            m_infl = 0;
            m_drop = 0;
            m_fifo.delete();
            m_tags.delete();
            mem_q.delete();
            mem_t.delete();
        end else begin
            if (m_valid && irdy && !redir) pop_q.push_back(inst_pc);
            accept    = m_req && rdy;
            rv_model  = rv_drive && (m_infl > 0);
            have_push = 1'b0;
            push_v    = 64'h0;
            if (rv_real) begin
                void'(mem_q.pop_front());
                void'(mem_t.pop_front());
            end
            if (rv_model) begin
                t = m_tags.pop_front();
                m_infl--;
                if (m_drop > 0) m_drop--;
                else begin
                    have_push = 1'b1;
                    push_v    = {rdata_v, t};
                end
            end
            if (accept) begin
                acc_q.push_back(m_pc);
                m_tags.push_back(m_pc);
                mem_q.push_back(m_pc);
                mem_t.push_back(cyc);
                m_pc = m_pc + 32'd4;
                m_infl++;
            end
            if (redir) begin
                m_fifo.delete();
                m_pc   = {rpc[31:2], 2'b00};
                m_drop = m_infl;
            end else begin
                if (m_valid && irdy) void'(m_fifo.pop_front());
                if (have_push) m_fifo.push_back(push_v);
            end
        end

        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        acc_q.delete();
        pop_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        if (inst_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", inst_valid);
        else n_pass++;
        n_checks++;
        if (inst !== NOP) $display("FAIL reset_inst got=%h exp=%h", inst, NOP);
        else n_pass++;
        n_checks++;
        if (inst_pc !== 32'h0) $display("FAIL reset_inst_pc got=%h exp=0", inst_pc);
        else n_pass++;
        n_checks++;
        if (imem_addr !== RESET_ADDR) $display("FAIL reset_addr got=%h exp=%h", imem_addr, RESET_ADDR);
        else n_pass++;
        n_checks++;
    endtask

    task automatic test_stream();
        logic [31:0] got;
        do_reset();
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            got = (acc_q.size() > i) ? acc_q[i] : 32'hxxxx_xxxx;
            if (got !== 32'(4 * i)) $display("FAIL stream_addr[%0d] got=%h exp=%h", i, got, 32'(4 * i));
            else n_pass++;
            n_checks++;
        end
        for (int i = 0; i < 3; i++) begin
            got = (pop_q.size() > i) ? pop_q[i] : 32'hxxxx_xxxx;
            if (got !== 32'(4 * i)) $display("FAIL stream_pc[%0d] got=%h exp=%h", i, got, 32'(4 * i));
            else n_pass++;
            n_checks++;
        end
    endtask

    task automatic test_stall();
        logic [31:0] got;
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        if (acc_q.size() != 2) $display("FAIL stall_nreq got=%0d exp=2", acc_q.size());
        else n_pass++;
        n_checks++;
        if (imem_req !== 1'b0) $display("FAIL stall_req got=%b exp=0", imem_req);
        else n_pass++;
        n_checks++;
        acc_q.delete();
        pop_q.delete();
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            got = (pop_q.size() > i) ? pop_q[i] : 32'hxxxx_xxxx;
            if (got !== 32'(4 * i)) $display("FAIL stall_pop[%0d] got=%h exp=%h", i, got, 32'(4 * i));
            else n_pass++;
            n_checks++;
        end
        got = (acc_q.size() > 0) ? acc_q[0] : 32'hxxxx_xxxx;
        if (got !== 32'h8) $display("FAIL stall_resume got=%h exp=00000008", got);
        else n_pass++;
        n_checks++;
    endtask

    task automatic test_redirect();
        logic [31:0] got;
        do_reset();
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        acc_q.delete();
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        got = (acc_q.size() > 1) ? acc_q[1] : 32'hxxxx_xxxx;
        if (got !== 32'hC) $display("FAIL redir_inflight got=%h exp=0000000c", got);
        else n_pass++;
        n_checks++;
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 1'b1);
        acc_q.delete();
        pop_q.delete();
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        got = (acc_q.size() > 0) ? acc_q[0] : 32'hxxxx_xxxx;
        if (got !== 32'h100) $display("FAIL redir_addr got=%h exp=00000100", got);
        else n_pass++;
        n_checks++;
        got = (pop_q.size() > 0) ? pop_q[0] : 32'hxxxx_xxxx;
        if (got !== 32'h100) $display("FAIL redir_pc got=%h exp=00000100", got);
        else n_pass++;
        n_checks++;
    endtask

    task automatic test_same_cycle();
        logic [31:0] got;
        do_reset();
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h203, 1'b1);
        if (imem_addr !== 32'h200) $display("FAIL same_addr got=%h exp=00000200", imem_addr);
        else n_pass++;
        n_checks++;
        acc_q.delete();
        pop_q.delete();
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        got = (pop_q.size() > 0) ? pop_q[0] : 32'hxxxx_xxxx;
        if (got !== 32'h200) $display("FAIL same_pc got=%h exp=00000200", got);
        else n_pass++;
        n_checks++;
    endtask

    task automatic test_wrap();
        logic [31:0] got;
        do_reset();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1);
        acc_q.delete();
        pop_q.delete();
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        got = (acc_q.size() > 1) ? acc_q[1] : 32'hxxxx_xxxx;
        if (got !== 32'h0) $display("FAIL wrap_addr got=%h exp=00000000", got);
        else n_pass++;
        n_checks++;
        got = (pop_q.size() > 0) ? pop_q[0] : 32'hxxxx_xxxx;
        if (got !== 32'hFFFF_FFFC) $display("FAIL wrap_pc0 got=%h exp=fffffffc", got);
        else n_pass++;
        n_checks++;
        got = (pop_q.size() > 1) ? pop_q[1] : 32'hxxxx_xxxx;
        if (got !== 32'h0) $display("FAIL wrap_pc1 got=%h exp=00000000", got);
        else n_pass++;
        n_checks++;
    endtask

    task automatic test_reset_full();
        do_reset();
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        if (inst_valid !== 1'b1) $display("FAIL full_valid got=%b exp=1", inst_valid);
        else n_pass++;
        n_checks++;
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        if (inst_valid !== 1'b0) $display("FAIL rstfull_valid got=%b exp=0", inst_valid);
        else n_pass++;
        n_checks++;
        if (inst !== NOP) $display("FAIL rstfull_inst got=%h exp=%h", inst, NOP);
        else n_pass++;
        n_checks++;
        if (imem_addr !== RESET_ADDR) $display("FAIL rstfull_addr got=%h exp=%h", imem_addr, RESET_ADDR);
        else n_pass++;
        n_checks++;
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    endtask

    task automatic test_bogus_rvalid();
        do_reset();
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        if (inst_valid !== 1'b0) $display("FAIL bogus_valid got=%b exp=0", inst_valid);
        else n_pass++;
        n_checks++;
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(99) < 1, $urandom_range(99) < 75, $urandom_range(99) < 70,
                  $urandom_range(99) < 3, $urandom_range(99) < 6, $urandom,
                  $urandom_range(99) < 70);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_same_cycle();
        test_wrap();
        test_reset_full();
        test_bogus_rvalid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
